// File: rtl/bcd_entry_pkg.sv
// rtl/bcd_entry_pkg.sv - shared widths and FSM state encoding for the BCD keypad entry block
package entry_pkg;
   localparam int DIGIT_W = 4;
   localparam int VALUE_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PRESENT = 2'd2
   } state_e;
endpackage

// File: rtl/bcd_entry_if.sv
// rtl/bcd_entry_if.sv - valid/ready value handoff from the entry block to the datapath
interface bcd_entry_if;
   import entry_pkg::*;

   logic [VALUE_W-1:0] value_out;
   logic               value_valid;
   logic               value_ready;

   modport master (output value_out, output value_valid, input value_ready);
   modport slave  (input value_out, input value_valid, output value_ready);
endinterface

// File: rtl/bcd_entry_key_conditioner.sv
// rtl/bcd_entry_key_conditioner.sv - synchronizer, optional debouncer, registered press pulse
// Debouncer present only when BCD_ENTRY_DEBOUNCE_EN is defined.
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic key_i,
   output logic press_o
);
   logic sync1_q, sync2_q;
   logic level;
   logic level_prev_q, press_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= key_i;
         sync2_q      <= sync1_q;
         level_prev_q <= level;
         press_q      <= level & ~level_prev_q;
      end
   end

`ifdef BCD_ENTRY_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive disagreeing samples; any agreement restarts the count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign level = deb_q;
`else
   logic unused_debounce_cfg;
   assign unused_debounce_cfg = ^32'(DEBOUNCE_CYCLES);
   assign level = sync2_q;
`endif

   assign press_o = press_q;
endmodule

// File: rtl/bcd_entry.sv
// rtl/bcd_entry.sv - keypad BCD digit accumulator presenting a binary value over valid/ready
// Key debouncing compiled in when BCD_ENTRY_DEBOUNCE_EN is defined.
module bcd_entry
   import entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MAX_DIGITS      = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] digit_sw,
   input  logic               key_enter,
   input  logic               key_done,
   bcd_entry_if.master        vbus,
   output logic [DIGIT_W-1:0] digit_count,
   output logic               err
);
   localparam logic [DIGIT_W-1:0] MAX_CNT = DIGIT_W'(MAX_DIGITS);

   logic enter_p, done_p;

   key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
      .clk(clk), .reset(reset), .key_i(key_enter), .press_o(enter_p)
   );
   key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done (
      .clk(clk), .reset(reset), .key_i(key_done), .press_o(done_p)
   );

   state_e             state_q, state_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic               valid_q, valid_d;
   logic [DIGIT_W-1:0] cnt_q, cnt_d;
   logic               err_q, err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      value_d = value_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE, ACCUM: begin
            // Done takes priority; a coincident digit is dropped.
            if (done_p) begin
               value_d = acc_q;
               valid_d = 1'b1;
               state_d = PRESENT;
            end else if (enter_p) begin
               if (digit_sw > 4'd9 || cnt_q >= MAX_CNT) begin
                  err_d = 1'b1;
               end else begin
                  acc_d   = acc_q * VALUE_W'(10) + VALUE_W'(digit_sw);
                  cnt_d   = cnt_q + 1'b1;
                  err_d   = 1'b0;
                  state_d = ACCUM;
               end
            end
         end
         PRESENT: begin
            if (vbus.value_ready) begin
               valid_d = 1'b0;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign vbus.value_out   = value_q;
   assign vbus.value_valid = valid_q;
   assign digit_count      = cnt_q;
   assign err              = err_q;
endmodule

// File: tb/tb_bcd_entry.sv
// tb/tb_bcd_entry.sv - scoreboard bench for bcd_entry (directed digit entry and handshake vectors)
module tb_bcd_entry;
   import entry_pkg::*;

`ifdef BCD_ENTRY_DEBOUNCE_EN
   localparam int DB     = 16;
   localparam int LAT    = DB + 4;
   localparam int SETTLE = DB + 6;
`else
   localparam int DB     = 16;
   localparam int LAT    = 4;
   localparam int SETTLE = 6;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic [DIGIT_W-1:0] digit_sw;
   logic               key_enter;
   logic               key_done;
   logic [DIGIT_W-1:0] digit_count;
   logic               err;

   bcd_entry_if vbus ();

   bcd_entry #(.DEBOUNCE_CYCLES(DB), .MAX_DIGITS(9)) dut (
      .clk(clk), .reset(reset), .digit_sw(digit_sw), .key_enter(key_enter),
      .key_done(key_done), .vbus(vbus), .digit_count(digit_count), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] value;
      logic [3:0]  count;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && vbus.value_valid && vbus.value_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_present", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_value", vbus.value_out, e.value);
            check("sb_count", 32'(digit_count), 32'(e.count));
         end
      end
   end

   task automatic cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(logic [3:0] d, logic en, logic dn);
      digit_sw  = d;
      key_enter = en;
      key_done  = dn;
      cycles(SETTLE);
      key_enter = 1'b0;
      key_done  = 1'b0;
      cycles(SETTLE);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic accept(int hold);
      logic [31:0] v;
      int k;
      k = 0;
      while (!vbus.value_valid && k < 50) begin
         cycles(1);
         k++;
      end
      check("valid_wait", 32'(vbus.value_valid), 32'd1);
      v = vbus.value_out;
      for (int i = 0; i < hold; i++) begin
         cycles(1);
         check("hold_valid", 32'(vbus.value_valid), 32'd1);
         check("hold_value", vbus.value_out, v);
      end
      @(posedge clk); #1 vbus.value_ready = 1'b1;
      @(posedge clk); #1 vbus.value_ready = 1'b0;
      @(negedge clk);
      check("post_valid", 32'(vbus.value_valid), 32'd0);
      check("post_count", 32'(digit_count), 32'd0);
      check("post_err", 32'(err), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      digit_sw = 4'd0;
      key_enter = 1'b0;
      key_done = 1'b0;
      vbus.value_ready = 1'b0;
      do_reset();
      check("rst_valid", 32'(vbus.value_valid), 32'd0);
      check("rst_value", vbus.value_out, 32'd0);
      check("rst_count", 32'(digit_count), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Press-to-update latency
      digit_sw  = 4'd6;
      key_enter = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1 check("lat_before", 32'(digit_count), 32'd0);
      @(posedge clk);
      #1 check("lat_after", 32'(digit_count), 32'd1);
      cycles(SETTLE);
      key_enter = 1'b0;
      cycles(SETTLE);
      sb.push_back('{32'd6, 4'd1});
      press(4'd0, 1'b0, 1'b1);
      accept(0);

      // 4,2,7 then done; enter/done during PRESENT ignored
      press(4'd4, 1'b1, 1'b0);
      press(4'd2, 1'b1, 1'b0);
      press(4'd7, 1'b1, 1'b0);
      check("cnt_427", 32'(digit_count), 32'd3);
      sb.push_back('{32'd427, 4'd3});
      press(4'd0, 1'b0, 1'b1);
      press(4'd5, 1'b1, 1'b0);
      press(4'd0, 1'b0, 1'b1);
      check("present_value", vbus.value_out, 32'd427);
      check("present_count", 32'(digit_count), 32'd3);
      accept(5);

      // Invalid digit and digit limit
      press(4'd12, 1'b1, 1'b0);
      check("bad_err", 32'(err), 32'd1);
      check("bad_count", 32'(digit_count), 32'd0);
      for (int i = 0; i < 9; i++) press(4'd9, 1'b1, 1'b0);
      check("nine_count", 32'(digit_count), 32'd9);
      check("nine_err", 32'(err), 32'd0);
      press(4'd9, 1'b1, 1'b0);
      check("ten_count", 32'(digit_count), 32'd9);
      check("ten_err", 32'(err), 32'd1);
      sb.push_back('{32'd999999999, 4'd9});
      press(4'd0, 1'b0, 1'b1);
      accept(1);

      // Stray ready, then simultaneous enter+done
      press(4'd3, 1'b1, 1'b0);
      @(posedge clk); #1 vbus.value_ready = 1'b1;
      @(posedge clk); #1 vbus.value_ready = 1'b0;
      @(negedge clk);
      check("stray_ready_count", 32'(digit_count), 32'd1);
      check("stray_ready_valid", 32'(vbus.value_valid), 32'd0);
      sb.push_back('{32'd3, 4'd1});
      press(4'd5, 1'b1, 1'b1);
      accept(1);

`ifdef BCD_ENTRY_DEBOUNCE_EN
      digit_sw = 4'd1;
      for (int i = 0; i < 4; i++) begin
         key_enter = (i % 2 == 0);
         cycles(3);
      end
      key_enter = 1'b1;
      cycles(20);
      key_enter = 1'b0;
      cycles(SETTLE);
      check("bounce_count", 32'(digit_count), 32'd1);
      sb.push_back('{32'd1, 4'd1});
      press(4'd0, 1'b0, 1'b1);
      accept(1);
`endif

      // Reset mid-entry
      press(4'd8, 1'b1, 1'b0);
      press(4'd1, 1'b1, 1'b0);
      check("mid_count", 32'(digit_count), 32'd2);
      do_reset();
      check("mid_rst_count", 32'(digit_count), 32'd0);
      check("mid_rst_valid", 32'(vbus.value_valid), 32'd0);
      check("mid_rst_value", vbus.value_out, 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      sb.push_back('{32'd0, 4'd0});
      press(4'd0, 1'b0, 1'b1);
      accept(1);

      cycles(5);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a key level change.
REQ-002 Parameter MAX_DIGITS, default 9: maximum accepted decimal digits, so 999999999 always fits in 32 bits.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 digit_sw  input  4  BCD digit from slide switches, sampled when an enter press is accepted.
REQ-006 key_enter  input  1  raw pushbutton, active-high, asynchronous to clk: append digit.
REQ-007 key_done  input  1  raw pushbutton, active-high, asynchronous to clk: finish entry.
REQ-008 value_out  output  32  completed binary value presented to the datapath.
REQ-009 value_valid  output  1  value_out is valid and held stable.
REQ-010 value_ready  input  1  datapath accepts value_out.
REQ-011 digit_count  output  4  number of digits accumulated so far.
REQ-012 err  output  1  sticky flag: an invalid or excess digit was rejected.

Function
REQ-013 Each key SHALL pass through a two-flop synchronizer, then a debouncer, then a rising-edge detector that yields a one-cycle press pulse.
REQ-014 Debouncer: the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any mismatch in between restarts the count.
REQ-015 The FSM SHALL have three states: IDLE (no digits), ACCUM (at least one digit), PRESENT (value_valid high).
REQ-016 Enter pulse in IDLE or ACCUM with digit_sw <= 9 and digit_count < MAX_DIGITS: acc <= acc*10 + digit_sw, digit_count += 1, err <= 0, next state ACCUM.
REQ-017 Enter pulse with digit_sw > 9: acc and digit_count unchanged, err <= 1.
REQ-018 Enter pulse with digit_count == MAX_DIGITS: acc and digit_count unchanged, err <= 1.
REQ-019 Done pulse in IDLE or ACCUM: value_out <= acc, value_valid <= 1, next state PRESENT; a done with zero digits SHALL present 0.
REQ-020 In PRESENT, value_out SHALL hold stable and value_valid SHALL stay high until a cycle with value_ready = 1.
REQ-021 On the value_ready handshake cycle: the next edge SHALL clear value_valid, acc, digit_count and err, and enter IDLE.
REQ-022 In PRESENT, enter and done pulses SHALL be ignored.
REQ-023 Simultaneous enter and done pulses: done wins, and the digit is discarded.
REQ-024 acc*10 SHALL be computed at 32-bit width; it cannot overflow given MAX_DIGITS <= 9.
REQ-025 A raw press held stable SHALL update acc and digit_count within DEBOUNCE_CYCLES+4 cycles.
REQ-026 value_ready while value_valid is low SHALL have no effect.

Reset
REQ-027 reset SHALL force, on the next clk edge: state IDLE, acc 0, value_out 0, value_valid 0, digit_count 0, err 0, synchronizers 0, debounced levels 0, debounce counters 0.
REQ-028 reset SHALL override any in-progress entry or pending handshake; a key still held after reset SHALL be seen as a new press once debounced.

Configuration
REQ-029 Macro BCD_ENTRY_DEBOUNCE_EN: when defined, the debouncer of REQ-014 SHALL be compiled in.
REQ-030 When BCD_ENTRY_DEBOUNCE_EN is undefined, the edge detector SHALL act directly on the synchronized level, DEBOUNCE_CYCLES SHALL be ignored, and press-to-update latency SHALL be 4 cycles.

Structure
REQ-031 Package entry_pkg SHALL hold the FSM state enum (IDLE, ACCUM, PRESENT), DIGIT_W = 4 and VALUE_W = 32.
REQ-032 Sub-module key_conditioner (synchronizer, optional debouncer, edge detector) SHALL be instantiated once per key.

Verification
REQ-033 Digit entry: press enter with digit_sw 4, 2, 7, then done -> value_out = 427, value_valid = 1, digit_count = 3.
REQ-034 Bounce: with debounce enabled, toggle key_enter every 3 cycles for 12 cycles, then hold high 20 cycles -> exactly one digit accepted.
REQ-035 Limits: enter digit_sw = 12 -> err = 1, digit_count unchanged; enter ten 9s -> acc = 999999999, err = 1 after the tenth.
REQ-036 Handshake: hold value_ready = 0 for 5 cycles after done -> value_out stable and value_valid high; assert value_ready -> next cycle value_valid = 0, digit_count = 0.
REQ-037 Simultaneous pulses: enter (digit_sw 5) and done in the same cycle after "3" -> value_out = 3.
REQ-038 Reset mid-entry: enter 8, 1, then reset -> all outputs 0, state IDLE; a following done presents 0.
